// File: rtl/uart_rx_if.sv
// Serial-receive bus: line and oversample tick in, decoded word out.
// rx_done_tick is a one-cycle valid with no ready; rx_dout/frame_err are meaningful while it is high and held after.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] rx_dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic [1:0]      dbg_state;

  modport master (
    output rx, s_tick,
    input  rx_dout, rx_done_tick, frame_err, dbg_state
  );

  modport slave (
    input  rx, s_tick,
    output rx_dout, rx_done_tick, frame_err, dbg_state
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: samples mid-bit, delivers each word with a
// one-cycle done pulse and a stop-bit framing-error flag.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [4:0]    SB_LAST  = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] BIT_LAST = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [DBIT-1:0] rx_dout_q, rx_dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            rx_meta_q, rx_meta_d;
  logic            rx_s_q, rx_s_d;

  // State register; sync flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      s_cnt_q   <= '0;
      n_cnt_q   <= '0;
      shreg_q   <= '0;
      rx_dout_q <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      s_cnt_q   <= s_cnt_d;
      n_cnt_q   <= n_cnt_d;
      shreg_q   <= shreg_d;
      rx_dout_q <= rx_dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
    end
  end

  // Next-state and datapath counters.
  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    n_cnt_d   = n_cnt_q;
    shreg_d   = shreg_q;
    rx_meta_d = bus.rx;
    rx_s_d    = rx_meta_q;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s_cnt_q == 5'd7) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_cnt_q == 5'd15) begin
            s_cnt_d = '0;
            shreg_d = {rx_s_q, shreg_q[DBIT-1:1]};
            if (n_cnt_q == BIT_LAST) state_d = STOP;
            else                     n_cnt_d = n_cnt_q + NW'(1);
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (s_cnt_q == SB_LAST) state_d = IDLE;
          else                    s_cnt_d = s_cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are captured on the stop-sample tick and presented one clk later.
  always_comb begin
    done_d    = (state_q == STOP) && bus.s_tick && (s_cnt_q == SB_LAST);
    rx_dout_d = done_d ? shreg_q : rx_dout_q;
    ferr_d    = done_d ? ~rx_s_q : ferr_q;
  end

  assign bus.rx_dout      = rx_dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: frames are pushed as {frame_err, data} on
// issue, and a monitor pops one entry per rx_done_tick.
module tb_uart_rx;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_if #(.DBIT(8)) bus ();
  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_pulse = -1;
  int         prev_pulse = -1;
  int         div = 0;
  logic       tick_en = 1'b1;
  logic [7:0] last_data = 8'h00;
  logic [8:0] exp_q[$];

  // ---------------- clock/tick generation ----------------
  always @(posedge clk) cyc <= cyc + 1;

  // Baud generator with a divide-by-4 terminal count: one tick every 4 clk.
  always @(negedge clk) begin
    if (!tick_en) begin
      bus.s_tick = 1'b0;
    end else begin
      div = (div + 1) % 4;
      bus.s_tick = (div == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (reset === 1'b0 && bus.rx_done_tick === 1'b1) begin
      prev_pulse = last_pulse;
      last_pulse = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got rx_done_tick=1 with dout=%0h expected no pulse (cycle %0d)",
                 bus.rx_dout, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rx_dout", {24'h0, bus.rx_dout}, {24'h0, e[7:0]});
        chk("frame_err", {31'h0, bus.frame_err}, {31'h0, e[8]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (bus.s_tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    @(negedge clk);
    bus.rx = b;
    wait_ticks(n);
  endtask

  // A bad stop bit is low for 12 ticks only, so the line is high again
  // before a spurious start could be confirmed.
  task automatic send_frame(input logic [7:0] data, input logic stop_ok, input logic expect_it);
    if (expect_it) begin
      exp_q.push_back({~stop_ok, data});
      last_data = data;
    end
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(data[i], 16);
    if (stop_ok) begin
      send_bit(1'b1, 16);
    end else begin
      send_bit(1'b0, 12);
      send_bit(1'b1, 20);
    end
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 3000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic check_cleared(input string name);
    chk({name, "_dout"}, {24'h0, bus.rx_dout}, 32'h0);
    chk({name, "_ferr"}, {31'h0, bus.frame_err}, 32'h0);
    chk({name, "_done"}, {31'h0, bus.rx_done_tick}, 32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int   diff;
    logic ok;
    logic [7:0] d;
    bus.rx = 1'b1;
    reset  = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_cleared("reset");
    send_bit(1'b1, 4);

    // T1: clean frame
    send_frame(8'hA5, 1'b1, 1'b1);
    send_bit(1'b1, 2);
    drain("t1_drain");

    // T2: short glitch must not produce a frame
    send_bit(1'b0, 5);
    send_bit(1'b1, 20);
    chk("t2_dout", {24'h0, bus.rx_dout}, {24'h0, last_data});
    chk("t2_ferr", {31'h0, bus.frame_err}, 32'h0);

    // T3: framing error, then a good frame
    send_frame(8'h3C, 1'b0, 1'b1);
    send_bit(1'b1, 4);
    send_frame(8'h81, 1'b1, 1'b1);
    send_bit(1'b1, 2);
    drain("t3_drain");

    // T4: back-to-back frames, 10 bits = 640 clk apart
    send_frame(8'h55, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_bit(1'b1, 2);
    drain("t4_drain");
    diff = last_pulse - prev_pulse;
    chk("t4_spacing", {31'h0, (diff >= 632 && diff <= 648)}, 32'h1);

    // T5: reset in the middle of data bit 3 aborts the frame
    fork
      send_frame(8'hF8, 1'b1, 1'b0);
      begin
        wait_ticks(16 + 3 * 16 + 8);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_cleared("t5_reset");
      end
    join
    send_bit(1'b1, 4);
    send_frame(8'h96, 1'b1, 1'b1);
    send_bit(1'b1, 2);
    drain("t5_drain");

    // T6: ticks stop for 100 clk mid DATA; the line is held with them
    fork
      send_frame(8'hC3, 1'b1, 1'b1);
      begin
        wait_ticks(16 + 2 * 16 + 5);
        @(negedge clk);
        tick_en = 1'b0;
        repeat (100) @(negedge clk);
        chk("t6_frozen_done", {31'h0, bus.rx_done_tick}, 32'h0);
        chk("t6_frozen_pending", exp_q.size(), 1);
        tick_en = 1'b1;
      end
    join
    send_bit(1'b1, 2);
    drain("t6_drain");

    // Random frames, random stop validity and gaps
    for (int k = 0; k < 16; k++) begin
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      send_frame(d, ok, 1'b1);
      if (!ok) send_bit(1'b1, 16 + $urandom_range(0, 8));
      else     send_bit(1'b1, $urandom_range(0, 3));
    end
    send_bit(1'b1, 4);
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
